// File: rtl/i2s_tx_if.sv
// Stereo sample type plus the bundle between the effects chain and the I2S transmitter.
package sample_pkg;
  typedef struct packed {
    logic signed [23:0] lc;
    logic signed [23:0] rc;
  } sample_t;
endpackage

interface i2s_tx_if;
  sample_pkg::sample_t data_i;
  logic                vld_i;
  logic                sclk_o;
  logic                lrck_o;
  logic                sdata_o;
  logic                req_o;
  logic                ovr_o;
  logic                udr_o;

  modport master (
    output data_i, vld_i,
    input  sclk_o, lrck_o, sdata_o, req_o, ovr_o, udr_o
  );

  modport slave (
    input  data_i, vld_i,
    output sclk_o, lrck_o, sdata_o, req_o, ovr_o, udr_o
  );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: derives SCLK/LRCK from clk, double-buffers one stereo
// sample and shifts it out MSB-first with a one-bit delay after each LRCK edge.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_DIV   = 8
) (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave bus
);

  localparam int B_W   = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_WIDTH - 1);
  localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_WIDTH);
  localparam logic [B_W-1:0]   B_DATA   = B_W'(DATA_WIDTH);
  localparam logic [B_W-1:0]   B_ONE    = B_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]             r_div;
  logic [B_W-1:0]               r_b;
  logic                         r_sclk;
  logic                         r_lrck;
  logic                         r_sdata;
  logic                         r_req;
  logic                         r_ovr;
  logic                         r_udr;
  logic                         r_fresh;
  logic signed [DATA_WIDTH-1:0] r_hold_l;
  logic signed [DATA_WIDTH-1:0] r_hold_r;
  logic signed [DATA_WIDTH-1:0] r_sh_l;
  logic signed [DATA_WIDTH-1:0] r_sh_r;

  logic                  w_tick;
  logic                  w_fe;
  logic                  w_load;
  logic [B_W-1:0]        w_b_next;
  logic                  w_lr_next;
  logic [B_W-1:0]        w_pos;
  logic [DATA_WIDTH-1:0] w_chan;
  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_bit;

  // Everything on the line is computed for the bit position being entered,
  // so the registered value lands exactly as SCLK falls.
  always_comb begin
    w_tick    = (r_div == DIV_LAST);
    w_fe      = w_tick && r_sclk;
    w_load    = w_fe && (r_b == B_LAST);
    w_b_next  = (r_b == B_LAST) ? '0 : r_b + B_ONE;
    w_lr_next = (w_b_next >= B_SLOT);
    w_pos     = w_lr_next ? (w_b_next - B_SLOT) : w_b_next;
    w_chan    = w_lr_next ? r_sh_r : r_sh_l;
    w_shift   = w_chan << (w_pos - B_ONE);
    w_bit     = ((w_pos >= B_ONE) && (w_pos <= B_DATA)) ? w_shift[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_b      <= B_LAST;
      r_sclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
      r_req    <= 1'b0;
      r_ovr    <= 1'b0;
      r_udr    <= 1'b0;
      r_fresh  <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
    end else begin
      r_req <= 1'b0;
      r_ovr <= 1'b0;
      r_udr <= 1'b0;

      if (w_tick) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_div <= r_div + DIV_ONE;
      end

      // Position 0 of every slot is padding, so a shadow update at the load
      // edge never races the bit being driven out.
      if (w_fe) begin
        r_b     <= w_b_next;
        r_lrck  <= w_lr_next;
        r_sdata <= w_bit;
      end

      if (w_load) begin
        r_req <= 1'b1;
        if (r_fresh) begin
          r_sh_l <= r_hold_l;
          r_sh_r <= r_hold_r;
          if (bus.vld_i) begin
            r_hold_l <= bus.data_i.lc;
            r_hold_r <= bus.data_i.rc;
          end else begin
            r_fresh <= 1'b0;
          end
        end else if (bus.vld_i) begin
          r_sh_l <= bus.data_i.lc;
          r_sh_r <= bus.data_i.rc;
        end else begin
          r_udr <= 1'b1;
        end
      end else if (bus.vld_i) begin
        r_hold_l <= bus.data_i.lc;
        r_hold_r <= bus.data_i.rc;
        r_fresh  <= 1'b1;
        r_ovr    <= r_fresh;
      end
    end
  end

  assign bus.sclk_o  = r_sclk;
  assign bus.lrck_o  = r_lrck;
  assign bus.sdata_o = r_sdata;
  assign bus.req_o   = r_req;
  assign bus.ovr_o   = r_ovr;
  assign bus.udr_o   = r_udr;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: table of strobes/probes per scenario, an I2S receiver that
// decodes the line, and a frame-level model of which sample each frame carries.
module tb_i2s_tx;
  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int SD    = 2;
  localparam int FRAME = 4 * SW * SD;
  localparam int FIRST = 2 * SD - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if bus ();

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SCLK_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // One row either drives a strobe, checks the outputs, or both, at cycle cyc.
  // exp bit order: {sclk, lrck, sdata, req, udr, ovr}
  typedef struct {
    int          cyc;
    bit          drv;
    logic [23:0] l;
    logic [23:0] r;
    bit          chk;
    logic [5:0]  exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [47:0] s;
  } stb_t;

  vec_t        vt[$];
  stb_t        slog[$];
  logic [47:0] rxq[$];
  int          reqq[$];
  int          udrq[$];
  int          ovrq[$];
  int          tests;
  int          fails;

  function automatic int ld(input int k);
    return FIRST + k * FRAME;
  endfunction

  function automatic logic [5:0] outs6();
    return {bus.sclk_o, bus.lrck_o, bus.sdata_o, bus.req_o, bus.udr_o, bus.ovr_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input int cyc, input logic [23:0] l, input logic [23:0] r);
    vt.push_back('{cyc, 1'b1, l, r, 1'b0, 6'b0});
  endtask

  task automatic probe(input int cyc, input logic [5:0] exp);
    vt.push_back('{cyc, 1'b0, 24'h0, 24'h0, 1'b1, exp});
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.vld_i   = 1'b0;
    bus.data_i  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs6()), 64'h0);
    rst = 1'b0;
  endtask

  // Frame-level reference: the newest sample that arrived strictly between two
  // loads goes out at the later load; a strobe coincident with a load is sent
  // immediately if nothing is pending, otherwise deferred one frame.
  task automatic model_check(input string name, input int nf, input int pad_err, input int edge_err);
    logic [47:0] prev, send, carry, last_item, at;
    bit          have_c, have_at;
    int          nitems, lo;
    int          eu[$];
    int          eo[$];
    logic [47:0] ef[$];
    prev   = '0;
    carry  = '0;
    have_c = 1'b0;
    for (int k = 0; k < nf; k++) begin
      lo        = (k == 0) ? -1 : ld(k - 1);
      nitems    = have_c ? 1 : 0;
      last_item = carry;
      have_at   = 1'b0;
      at        = '0;
      foreach (slog[i]) begin
        if (slog[i].cyc > lo && slog[i].cyc < ld(k)) begin
          if (nitems > 0) eo.push_back(slog[i].cyc + 1);
          nitems++;
          last_item = slog[i].s;
        end else if (slog[i].cyc == ld(k)) begin
          have_at = 1'b1;
          at      = slog[i].s;
        end
      end
      have_c = 1'b0;
      if (nitems > 0) begin
        send = last_item;
        if (have_at) begin
          have_c = 1'b1;
          carry  = at;
        end
      end else if (have_at) begin
        send = at;
      end else begin
        send = prev;
        eu.push_back(ld(k) + 1);
      end
      prev = send;
      ef.push_back(send);
    end

    check({name, "_nframes"}, 64'(rxq.size()), 64'(nf));
    for (int k = 0; k < nf && k < rxq.size(); k++)
      check($sformatf("%s_frame%0d", name, k), 64'(rxq[k]), 64'(ef[k]));
    check({name, "_nreq"}, 64'(reqq.size()), 64'(nf));
    for (int k = 0; k < nf && k < reqq.size(); k++)
      check($sformatf("%s_req%0d", name, k), 64'(reqq[k]), 64'(ld(k) + 1));
    check({name, "_nudr"}, 64'(udrq.size()), 64'(eu.size()));
    for (int k = 0; k < eu.size() && k < udrq.size(); k++)
      check($sformatf("%s_udr%0d", name, k), 64'(udrq[k]), 64'(eu[k]));
    check({name, "_novr"}, 64'(ovrq.size()), 64'(eo.size()));
    for (int k = 0; k < eo.size() && k < ovrq.size(); k++)
      check($sformatf("%s_ovr%0d", name, k), 64'(ovrq[k]), 64'(eo[k]));
    check({name, "_padding"}, 64'(pad_err), 64'h0);
    check({name, "_edges"}, 64'(edge_err), 64'h0);
  endtask

  task automatic run_test(input string name, input int nf, input int abort_at);
    int          dp, pad_err, edge_err, last;
    bit          dlr, psclk, psdata, plrck;
    logic [23:0] dword, dleft;
    slog.delete();
    rxq.delete();
    reqq.delete();
    udrq.delete();
    ovrq.delete();
    do_reset();
    dp       = -2;
    dlr      = 1'b0;
    psclk    = 1'b0;
    psdata   = 1'b0;
    plrck    = 1'b0;
    pad_err  = 0;
    edge_err = 0;
    dword    = '0;
    dleft    = '0;
    last     = ld(nf - 1) + 245;
    for (int c = 0; c <= last; c++) begin
      if ((bus.sdata_o !== psdata || bus.lrck_o !== plrck) && !(psclk && !bus.sclk_o))
        edge_err++;
      if (bus.sclk_o && !psclk) begin
        if (bus.lrck_o != dlr) begin
          dlr = bus.lrck_o;
          dp  = 0;
        end else begin
          dp++;
        end
        if (dp >= 1 && dp <= DW) dword = {dword[DW-2:0], bus.sdata_o};
        else if (bus.sdata_o) pad_err++;
        if (dp == DW) begin
          if (!dlr) dleft = dword;
          else rxq.push_back({dleft, dword});
        end
      end
      if (bus.req_o) reqq.push_back(c);
      if (bus.udr_o) udrq.push_back(c);
      if (bus.ovr_o) ovrq.push_back(c);
      psclk  = bus.sclk_o;
      psdata = bus.sdata_o;
      plrck  = bus.lrck_o;

      if (c == abort_at) begin
        rst       = 1'b1;
        bus.vld_i = 1'b0;
        @(negedge clk);
        check({name, "_abort_zero"}, 64'(outs6()), 64'h0);
        return;
      end

      bus.vld_i = 1'b0;
      foreach (vt[i]) begin
        if (vt[i].cyc == c) begin
          if (vt[i].chk)
            check($sformatf("%s_c%0d", name, c), 64'(outs6()), 64'(vt[i].exp));
          if (vt[i].drv) begin
            bus.vld_i     = 1'b1;
            bus.data_i.lc = vt[i].l;
            bus.data_i.rc = vt[i].r;
            slog.push_back('{c, {vt[i].l, vt[i].r}});
          end
        end
      end
      @(negedge clk);
    end
    bus.vld_i = 1'b0;
    model_check(name, nf, pad_err, edge_err);
  endtask

  task automatic first_frame_rows();
    vt.delete();
    probe(0,   6'b000000);
    probe(1,   6'b000000);
    probe(2,   6'b100000);
    probe(3,   6'b100000);
    probe(4,   6'b000110);
    probe(5,   6'b000000);
    probe(131, 6'b100000);
    probe(132, 6'b010000);
    probe(259, 6'b110000);
    probe(260, 6'b000110);
    probe(261, 6'b000000);
  endtask

  initial begin
    int c1;
    tests      = 0;
    fails      = 0;
    bus.vld_i  = 1'b0;
    bus.data_i = '0;

    first_frame_rows();
    run_test("first", 2, -1);

    vt.delete();
    strobe(1, 24'hA5F00F, 24'h123456);
    probe(4,   6'b000100);
    probe(7,   6'b100000);
    probe(8,   6'b001000);
    probe(10,  6'b101000);
    probe(12,  6'b000000);
    probe(16,  6'b001000);
    probe(131, 6'b100000);
    probe(132, 6'b010000);
    probe(136, 6'b010000);
    probe(148, 6'b011000);
    probe(259, 6'b110000);
    probe(260, 6'b000110);
    run_test("pattern", 2, -1);

    vt.delete();
    strobe(50, 24'h111111, 24'h222222);
    strobe(60, 24'h7ABCDE, 24'h876543);
    probe(51, 6'b100000);
    probe(61, 6'b000001);
    run_test("overrun", 2, -1);

    vt.delete();
    strobe(100, 24'($urandom), 24'($urandom));
    run_test("underrun", 5, -1);

    vt.delete();
    strobe(3,   24'hC00001, 24'h3FFFFE);
    strobe(200, 24'h0F0F0F, 24'hF0F0F0);
    strobe(259, 24'h800000, 24'h7FFFFF);
    probe(4,   6'b000100);
    probe(260, 6'b000100);
    probe(516, 6'b000100);
    run_test("coincident", 3, -1);

    for (int it = 0; it < 2; it++) begin
      vt.delete();
      if ($urandom % 2 == 0) strobe(int'($urandom_range(0, 2)), 24'($urandom), 24'($urandom));
      for (int k = 0; k < 6; k++) begin
        if (k > 0) begin
          int n;
          n = int'($urandom_range(0, 2));
          c1 = ld(k - 1) + int'($urandom_range(1, 120));
          if (n >= 1) strobe(c1, 24'($urandom), 24'($urandom));
          if (n == 2) strobe(c1 + int'($urandom_range(1, 120)), 24'($urandom), 24'($urandom));
        end
        if ($urandom % 3 == 0) strobe(ld(k), 24'($urandom), 24'($urandom));
      end
      run_test($sformatf("random%0d", it), 6, -1);
    end

    vt.delete();
    strobe(1, 24'hFFFFFF, 24'hFFFFFF);
    run_test("midreset", 2, 164);
    first_frame_rows();
    run_test("after_reset", 2, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
